inv_bist_checker: RTL and testbench

- Hardware self-test engine for the 6-bit hex-inverter primitive used in the discrete-logic CPU datapath.
- Drives every input pattern into a 7404-style device, waits a settle interval, then checks each output against the bitwise inverse of the input.
- Reports pass/fail, the error count and the first failing vector.
- Runs unattended in the CPU's power-on test sequence; no testbench is needed at run time.

---
 rtl/bist_pkg.sv | 21 ++
 rtl/bist_settle_timer.sv | 31 +++
 rtl/inv_bist_checker.sv | 141 ++++++++++++++
 tb/tb_inv_bist_checker.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bist_pkg.sv
// Shared definitions for the TTL-part self-test engines.
package bist_pkg;

  // FSM encoding shared by the BIST checkers.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_DRIVE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_DONE   = 3'd4
  } bist_state_t;

  // Widest part any checker drives; narrower parts zero-extend into it.
  localparam int MAX_W = 16;

  // Ideal response of an inverter channel: the bitwise inverse of its input.
  function automatic logic [MAX_W-1:0] expected_inv(input logic [MAX_W-1:0] a);
    return ~a;
  endfunction

endpackage

// File: rtl/bist_settle_timer.sv
// Loadable down-counter that times the settle interval after each new vector.
// With SETTLE=0 the checker never enters its wait state, so the timer is unused.
module bist_settle_timer #(
  parameter int SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic dec,
  output logic zero
);

  localparam int TW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [TW-1:0] LOAD_VAL = (SETTLE > 0) ? TW'(SETTLE - 1) : '0;

  logic [TW-1:0] count;

  // Load SETTLE-1 so the wait state lasts exactly SETTLE cycles, then count down to zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/inv_bist_checker.sv
// Self-test engine for the hex inverter: sweeps every input vector, waits for
// the part to settle, and checks each output against the inverted input.
module inv_bist_checker
  import bist_pkg::*;
#(
  parameter int WIDTH  = 6,
  parameter int SETTLE = 2,
  parameter int NVEC   = 2**WIDTH,
  parameter int CW     = $clog2(NVEC + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] dut_a,
  input  logic [WIDTH-1:0] dut_y,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    err_count,
  output logic [WIDTH-1:0] fail_vec,
  output logic [WIDTH-1:0] fail_y
);

  bist_state_t state, state_next;

  logic [WIDTH-1:0] vec;
  logic             last_vec;
  logic             tmr_load;
  logic             tmr_dec;
  logic             tmr_zero;

  logic [WIDTH-1:0] y_n;
  logic [MAX_W-1:0] a_ext;
  logic [MAX_W-1:0] exp_full;
  logic [MAX_W-1:0] obs_full;
  logic             mismatch;

  assign last_vec = (vec == WIDTH'(NVEC - 1));

  // The shared expected_inv works at MAX_W bits. Zero-extending dut_a gives ones
  // in the unused upper bits of the expectation, so the observed side is built
  // as ~zext(~dut_y) to carry matching ones there and dut_y in the low bits.
  // Case inequality makes X/Z on dut_y count as a failure in simulation.
  assign y_n      = ~dut_y;
  assign a_ext    = MAX_W'(dut_a);
  assign obs_full = ~(MAX_W'(y_n));
  assign exp_full = expected_inv(a_ext);
  assign mismatch = (obs_full !== exp_full);

  bist_settle_timer #(
    .SETTLE(SETTLE)
  ) u_timer (
    .clk  (clk),
    .rst  (rst),
    .load (tmr_load),
    .dec  (tmr_dec),
    .zero (tmr_zero)
  );

  // State register; reset aborts any run in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs; the wait state is skipped when SETTLE is 0.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    pass       = 1'b0;
    tmr_load   = 1'b0;
    tmr_dec    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_DRIVE;
      end
      ST_DRIVE: begin
        busy       = 1'b1;
        tmr_load   = 1'b1;
        state_next = (SETTLE > 0) ? ST_SETTLE : ST_CHECK;
      end
      ST_SETTLE: begin
        busy = 1'b1;
        if (tmr_zero) state_next = ST_CHECK;
        else          tmr_dec    = 1'b1;
      end
      ST_CHECK: begin
        busy       = 1'b1;
        state_next = last_vec ? ST_DONE : ST_DRIVE;
      end
      ST_DONE: begin
        done = 1'b1;
        pass = (err_count == '0);
        if (start) state_next = ST_DRIVE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Vector sequencing, stimulus register and error bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      dut_a     <= '0;
      vec       <= '0;
      err_count <= '0;
      fail_vec  <= '0;
      fail_y    <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            vec       <= '0;
            err_count <= '0;
            fail_vec  <= '0;
            fail_y    <= '0;
          end
        end
        ST_DRIVE: begin
          dut_a <= vec;
        end
        ST_CHECK: begin
          if (mismatch) begin
            if (err_count == '0) begin
              fail_vec <= dut_a;
              fail_y   <= dut_y;
            end
            if (err_count != '1) err_count <= err_count + 1'b1;
          end
          if (!last_vec) vec <= vec + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_bist_checker.sv
// Self-checking bench for inv_bist_checker: a default instance (SETTLE=2) driven
// by a configurable device model, and a SETTLE=0 instance with a good inverter.
module tb_inv_bist_checker;
  import bist_pkg::*;

  localparam int NVEC = 64;

  typedef struct {
    int         lat;
    logic       pass;
    logic [6:0] errs;
    logic [5:0] fvec;
    logic [5:0] fy;
    logic [5:0] last_a;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [5:0] dut_a0, dut_y0, fail_vec0, fail_y0;
  logic [5:0] dut_a1, dut_y1, fail_vec1, fail_y1;
  logic       busy0, done0, pass0, busy1, done1, pass1;
  logic [6:0] err0, err1;

  int   mode0 = 0;
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   overlap = 0;
  int   settle_visits0 = 0;
  int   settle_visits1 = 0;
  exp_t sb[$];

  // Device model: 0 = good inverter, 1 = output 2 stuck high, 2 = buffer.
  function automatic logic [5:0] model_y(input logic [5:0] a, input int m);
    case (m)
      1:       return ~a | 6'b000100;
      2:       return a;
      default: return ~a;
    endcase
  endfunction

  assign dut_y0 = model_y(dut_a0, mode0);
  assign dut_y1 = ~dut_a1;

  inv_bist_checker #(.WIDTH(6), .SETTLE(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .dut_a(dut_a0), .dut_y(dut_y0),
    .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
    .fail_vec(fail_vec0), .fail_y(fail_y0)
  );

  inv_bist_checker #(.WIDTH(6), .SETTLE(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_a(dut_a1), .dut_y(dut_y1),
    .busy(busy1), .done(done1), .pass(pass1), .err_count(err1),
    .fail_vec(fail_vec1), .fail_y(fail_y1)
  );

  always #5 clk = ~clk;

  // Free-running count of rising edges, used to measure run latency.
  always @(posedge clk) cyc <= cyc + 1;

  // Watch for busy/done overlap and record which instances visit the wait state.
  always @(negedge clk) begin
    if ((busy0 && done0) || (busy1 && done1)) overlap <= overlap + 1;
    if (u_dut0.state == ST_SETTLE) settle_visits0 <= settle_visits0 + 1;
    if (u_dut1.state == ST_SETTLE) settle_visits1 <= settle_visits1 + 1;
  end

  // Build the expected outcome of a full sweep from the device model.
  task automatic push_expected(input int mode, input int per_vec);
    exp_t e;
    e.lat    = 1 + NVEC * per_vec;
    e.errs   = '0;
    e.fvec   = '0;
    e.fy     = '0;
    e.last_a = 6'(NVEC - 1);
    for (int v = 0; v < NVEC; v++) begin
      logic [5:0] a;
      logic [5:0] y;
      a = 6'(v);
      y = model_y(a, mode);
      if (y !== ~a) begin
        if (e.errs == 0) begin
          e.fvec = a;
          e.fy   = y;
        end
        e.errs = e.errs + 1'b1;
      end
    end
    e.pass = (e.errs == 0);
    sb.push_back(e);
  endtask

  // Wait (bounded) for done on one instance; lat is -1 if it never arrives.
  task automatic wait_done(input int inst, input int e0, input bit keep_start,
                           output int lat, output int first_busy, output int last_busy);
    lat        = -1;
    first_busy = -1;
    last_busy  = -1;
    for (int i = 0; i < 1000; i++) begin
      logic b, d;
      @(negedge clk);
      if (!keep_start) begin
        start0 = 1'b0;
        start1 = 1'b0;
      end
      b = (inst == 0) ? busy0 : busy1;
      d = (inst == 0) ? done0 : done1;
      if (b) begin
        if (first_busy < 0) first_busy = cyc - e0;
        last_busy = cyc - e0;
      end
      if (d) begin
        lat = cyc - e0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({busy0, done0, pass0} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL reset_status0: got %b expected 000", {busy0, done0, pass0});
    end
    vectors++;
    if ({dut_a0, fail_vec0, fail_y0, err0} !== 25'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_regs0: got a=%h fv=%h fy=%h err=%0d expected all 0", dut_a0, fail_vec0, fail_y0, err0);
    end
    vectors++;
    if ({busy1, done1, pass1, dut_a1, fail_vec1, fail_y1, err1} !== 28'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_inst1: got b=%b d=%b p=%b a=%h err=%0d expected all 0", busy1, done1, pass1, dut_a1, err1);
    end
  endtask

  task automatic test_good_inverter();
    exp_t e;
    int e0, lat, fb, lb;
    mode0 = 0;
    push_expected(0, 4);
    start0 = 1'b1;
    e0 = cyc;
    wait_done(0, e0, 1'b0, lat, fb, lb);
    e = sb.pop_front();
    vectors++;
    if (lat !== e.lat) begin
      miscompares++;
      $display("[TB] FAIL good_latency: got %0d expected %0d", lat, e.lat);
    end
    vectors++;
    if (fb !== 1 || lb !== e.lat - 1) begin
      miscompares++;
      $display("[TB] FAIL good_busy_window: got %0d..%0d expected 1..%0d", fb, lb, e.lat - 1);
    end
    vectors++;
    if (pass0 !== e.pass || err0 !== e.errs) begin
      miscompares++;
      $display("[TB] FAIL good_result: got pass=%b err=%0d expected pass=%b err=%0d", pass0, err0, e.pass, e.errs);
    end
    vectors++;
    if (dut_a0 !== e.last_a) begin
      miscompares++;
      $display("[TB] FAIL good_final_a: got %b expected %b", dut_a0, e.last_a);
    end
    vectors++;
    if (fail_vec0 !== e.fvec || fail_y0 !== e.fy) begin
      miscompares++;
      $display("[TB] FAIL good_fail_capture: got %b/%b expected %b/%b", fail_vec0, fail_y0, e.fvec, e.fy);
    end
  endtask

  task automatic test_stuck_bit();
    exp_t e;
    int e0, lat, fb, lb;
    mode0 = 1;
    push_expected(1, 4);
    start0 = 1'b1;
    e0 = cyc;
    wait_done(0, e0, 1'b0, lat, fb, lb);
    e = sb.pop_front();
    vectors++;
    if (lat !== e.lat) begin
      miscompares++;
      $display("[TB] FAIL stuck_latency: got %0d expected %0d", lat, e.lat);
    end
    vectors++;
    if (pass0 !== e.pass || err0 !== e.errs) begin
      miscompares++;
      $display("[TB] FAIL stuck_result: got pass=%b err=%0d expected pass=%b err=%0d", pass0, err0, e.pass, e.errs);
    end
    vectors++;
    if (fail_vec0 !== e.fvec || fail_y0 !== e.fy) begin
      miscompares++;
      $display("[TB] FAIL stuck_fail_capture: got %b/%b expected %b/%b", fail_vec0, fail_y0, e.fvec, e.fy);
    end
  endtask

  task automatic test_buffer();
    exp_t e;
    int e0, lat, fb, lb;
    mode0 = 2;
    push_expected(2, 4);
    start0 = 1'b1;
    e0 = cyc;
    wait_done(0, e0, 1'b0, lat, fb, lb);
    e = sb.pop_front();
    vectors++;
    if (pass0 !== e.pass || err0 !== e.errs || lat !== e.lat) begin
      miscompares++;
      $display("[TB] FAIL buffer_result: got pass=%b err=%0d lat=%0d expected pass=%b err=%0d lat=%0d", pass0, err0, lat, e.pass, e.errs, e.lat);
    end
    vectors++;
    if (fail_vec0 !== e.fvec || fail_y0 !== e.fy) begin
      miscompares++;
      $display("[TB] FAIL buffer_fail_capture: got %b/%b expected %b/%b", fail_vec0, fail_y0, e.fvec, e.fy);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    int e0, lat, fb, lb;
    mode0 = 2;
    start0 = 1'b1;
    e0 = cyc;
    @(negedge clk);
    start0 = 1'b0;
    while (cyc - e0 < 100) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vectors++;
    if ({busy0, done0, pass0} !== 3'b000) begin
      miscompares++;
      $display("[TB] FAIL midreset_status: got %b expected 000", {busy0, done0, pass0});
    end
    vectors++;
    if ({dut_a0, fail_vec0, fail_y0, err0} !== 25'd0) begin
      miscompares++;
      $display("[TB] FAIL midreset_regs: got a=%h fv=%h fy=%h err=%0d expected all 0", dut_a0, fail_vec0, fail_y0, err0);
    end
    mode0 = 0;
    push_expected(0, 4);
    start0 = 1'b1;
    e0 = cyc;
    wait_done(0, e0, 1'b0, lat, fb, lb);
    e = sb.pop_front();
    vectors++;
    if (lat !== e.lat || pass0 !== e.pass || err0 !== e.errs) begin
      miscompares++;
      $display("[TB] FAIL midreset_rerun: got lat=%0d pass=%b err=%0d expected lat=%0d pass=%b err=%0d", lat, pass0, err0, e.lat, e.pass, e.errs);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int e0, lat, fb, lb;
    mode0 = 0;
    push_expected(0, 4);
    start0 = 1'b1;
    e0 = cyc;
    while (cyc - e0 < 49) @(negedge clk);
    start0 = 1'b0;
    @(negedge clk);
    start0 = 1'b1;
    wait_done(0, e0, 1'b1, lat, fb, lb);
    e = sb.pop_front();
    vectors++;
    if (lat !== e.lat || pass0 !== e.pass) begin
      miscompares++;
      $display("[TB] FAIL held_start_done: got lat=%0d pass=%b expected lat=%0d pass=%b", lat, pass0, e.lat, e.pass);
    end
    @(negedge clk);
    vectors++;
    if ({busy0, done0, pass0} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL held_start_restart: got busy/done/pass=%b expected 100", {busy0, done0, pass0});
    end
    start0 = 1'b0;
    push_expected(0, 4);
    wait_done(0, e0 + e.lat, 1'b0, lat, fb, lb);
    e = sb.pop_front();
    vectors++;
    if (lat !== e.lat || pass0 !== e.pass || err0 !== e.errs) begin
      miscompares++;
      $display("[TB] FAIL held_start_second_run: got lat=%0d pass=%b err=%0d expected lat=%0d pass=%b err=%0d", lat, pass0, err0, e.lat, e.pass, e.errs);
    end
  endtask

  task automatic test_settle_zero();
    exp_t e;
    int e0, lat, fb, lb;
    push_expected(0, 2);
    start1 = 1'b1;
    e0 = cyc;
    wait_done(1, e0, 1'b0, lat, fb, lb);
    e = sb.pop_front();
    vectors++;
    if (lat !== e.lat || fb !== 1 || lb !== e.lat - 1) begin
      miscompares++;
      $display("[TB] FAIL settle0_timing: got lat=%0d busy %0d..%0d expected lat=%0d busy 1..%0d", lat, fb, lb, e.lat, e.lat - 1);
    end
    vectors++;
    if (pass1 !== e.pass || err1 !== e.errs || dut_a1 !== e.last_a) begin
      miscompares++;
      $display("[TB] FAIL settle0_result: got pass=%b err=%0d a=%b expected pass=%b err=%0d a=%b", pass1, err1, dut_a1, e.pass, e.errs, e.last_a);
    end
    vectors++;
    if (settle_visits1 !== 0) begin
      miscompares++;
      $display("[TB] FAIL settle0_state_coverage: got %0d wait-state cycles expected 0", settle_visits1);
    end
    vectors++;
    if (!(settle_visits0 > 0)) begin
      miscompares++;
      $display("[TB] FAIL settle2_state_coverage: got %0d wait-state cycles expected nonzero", settle_visits0);
    end
  endtask

  initial begin
    $display("[TB] inv_bist_checker bench starting");
    test_reset();
    test_good_inverter();
    test_stuck_bit();
    test_buffer();
    test_reset_mid_run();
    test_back_to_back();
    test_settle_zero();
    vectors++;
    if (overlap !== 0) begin
      miscompares++;
      $display("[TB] FAIL busy_done_overlap: got %0d cycles expected 0", overlap);
    end
    vectors++;
    if (sb.size() !== 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
